knn_local_buf_stream_reader: RTL
================================

// Module: knn_local_buf_stream_reader
// PURPOSE
// - Read-side client of a partialKnn local scratchpad (URAM 1R1W, ap_memory-style address0/ce0/we0/d0/q0).
// - Accepts {base,len} commands, issues sequential reads and absorbs the fixed memory read latency.
// - Emits the words as a valid/ready stream with last, with full backpressure and 1 word/cycle throughput.
// - Sits between the local SP buffer and the distance/compare pipeline of each partialKnn wrapper.
// PARAMETERS
// - DataWidth     256   memory word / stream width
// - AddressRange  2048  words in the attached memory
// - AddressWidth  11    log2(AddressRange)
// - RD_LAT        2     cycles from ce0 (read) to q0 valid at the memory; legal range 1..4
// - FIFO_DEPTH    RD_LAT+2  output skid FIFO depth in words; must be >= RD_LAT+1
// PORTS
// - clk         in   1               rising-edge clock
// - reset       in   1               synchronous, active-high reset
// - cmd_valid   in   1               command offered
// - cmd_ready   out  1               high only in IDLE
// - cmd_base    in   AddressWidth    first word address
// - cmd_len     in   AddressWidth+1  words to read, 0..AddressRange
// - address0    out  AddressWidth    memory address
// - ce0         out  1               memory enable (one read per cycle it is high)
// - we0         out  1               tied 0
// - d0          out  DataWidth       tied 0
// - q0          in   DataWidth       memory read data, valid RD_LAT cycles after ce0
// - m_valid     out  1               stream word valid
// - m_ready     in   1               downstream accepts
// - m_data      out  DataWidth       stream word
// - m_last      out  1               marks final word of the command
// - busy        out  1               state != IDLE
// - done        out  1               one-cycle pulse when a command completes
// BEHAVIOUR
// - Reset values: cmd_ready=0 during reset, 1 the first cycle after; ce0=0, address0=0, m_valid=0, m_last=0, busy=0, done=0.
// - States: IDLE -> RUN on cmd_valid&&cmd_ready with cmd_len!=0; IDLE -> IDLE with done=1 next cycle when cmd_len==0.
// - RUN: issue read when issued<len and (inflight + fifo_count) < FIFO_DEPTH; RUN -> DRAIN after last read issued.
// - DRAIN -> IDLE when the last word (m_last) handshakes; done=1 in the cycle after, cmd_ready=1 in that same cycle.
// - Credit rule guarantees no q0 word is ever dropped; ce0 held 0 while credits exhausted.
// - Inflight tracked by an RD_LAT-deep valid shift register; q0 written to FIFO when its tap is 1.
// - Address: address0 = (cmd_base + k) mod AddressRange, k = 0..len-1; wraps AddressRange-1 -> 0.
// - cmd_len > AddressRange saturates to AddressRange (each word read exactly once).
// - Latency: cmd accepted at T -> first ce0 at T+1 -> FIFO write at T+1+RD_LAT -> m_valid at T+2+RD_LAT.
// - Throughput: with m_ready held 1, one word per cycle, no bubbles after the first.
// - m_data/m_valid/m_last stable while m_valid&&!m_ready (AXI-stream rules); m_last set only on word len-1.
// - cmd_valid ignored outside IDLE; no command queueing.
// - reset mid-operation: FIFO, inflight shift register and counters cleared; late q0 words discarded; no done pulse.
// CONFIGURATION
// - KNN_RDR_PERF_EN defined: adds outputs perf_stall_cycles[31:0] (cycles with m_valid&&!m_ready) and
//   perf_credit_cycles[31:0] (RUN cycles with read pending but no credit); both saturate at 2^32-1,
//   clear on reset and on each command accept.
// - KNN_RDR_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - base=0,len=4,RD_LAT=2,m_ready=1 -> ce0 at T+1..T+4, addr 0..3, m_valid T+4..T+7, m_last at T+7, done at T+8.
// - base=2046,len=4 -> address0 sequence 2046,2047,0,1; data order matches memory preload.
// - len=0 -> no ce0, no m_valid, done pulse exactly one cycle after accept, cmd_ready stays high.
// - len=16, m_ready random 50% -> all 16 words in order, no loss/dup; inflight+fifo never > FIFO_DEPTH.
// - len=16, m_ready=0 for 20 cycles -> ce0 stops after FIFO_DEPTH reads, m_data held stable, resumes on m_ready=1.
// - reset asserted mid-RUN with reads inflight -> next cycle m_valid=0, busy=0; new cmd base=8,len=2 returns words 8,9 only.

Source files
------------

// File: rtl/knn_local_buf_stream_reader.sv
// Streams {base,len} runs of scratchpad words out of a fixed-latency read port with credit-based skid buffering.
// Optional macro KNN_RDR_PERF_EN adds saturating stall / credit-starvation counters.
module knn_local_buf_stream_reader #(
  parameter int DataWidth    = 256,
  parameter int AddressRange = 2048,
  parameter int AddressWidth = 11,
  parameter int RD_LAT       = 2,
  parameter int FIFO_DEPTH   = RD_LAT + 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [AddressWidth-1:0] cmd_base,
  input  logic [AddressWidth:0]   cmd_len,
  output logic [AddressWidth-1:0] address0,
  output logic                    ce0,
  output logic                    we0,
  output logic [DataWidth-1:0]    d0,
  input  logic [DataWidth-1:0]    q0,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DataWidth-1:0]    m_data,
  output logic                    m_last,
  output logic                    busy,
  output logic                    done
`ifdef KNN_RDR_PERF_EN
  ,
  output logic [31:0]             perf_stall_cycles,
  output logic [31:0]             perf_credit_cycles
`endif
);

  localparam int LenW = AddressWidth + 1;
  localparam int CntW = $clog2(FIFO_DEPTH + 1);
  localparam int PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SumW = $clog2(FIFO_DEPTH + RD_LAT + 2);
  localparam logic [LenW-1:0]         MaxLen   = LenW'(AddressRange);
  localparam logic [AddressWidth-1:0] LastAddr = AddressWidth'(AddressRange - 1);
  localparam logic [PtrW-1:0]         LastPtr  = PtrW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  ready_r;
  logic [LenW-1:0]       len_r;
  logic [LenW-1:0]       issued_r;
  logic [LenW-1:0]       len_sat_s;
  logic                  accept_s;
  logic                  first_issue_s;
  logic                  issue_s;
  logic                  pending_s;
  logic                  credit_ok_s;
  logic                  last_read_s;
  logic                  pop_s;
  logic                  push_s;
  logic [SumW-1:0]       outstanding_s;
  logic                  ce_last_r;
  logic [RD_LAT-1:0]     vld_pipe_r;
  logic [RD_LAT-1:0]     last_pipe_r;
  logic [DataWidth-1:0]  fifo_data_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_r;
  logic [PtrW-1:0]       wr_ptr_r;
  logic [PtrW-1:0]       rd_ptr_r;
  logic [CntW-1:0]       fifo_cnt_r;

  function automatic logic [AddressWidth-1:0] addr_inc(input logic [AddressWidth-1:0] a);
    return (a == LastAddr) ? {AddressWidth{1'b0}} : a + AddressWidth'(1);
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? {PtrW{1'b0}} : p + PtrW'(1);
  endfunction

  assign we0       = 1'b0;
  assign d0        = {DataWidth{1'b0}};
  // ready is forced low while reset is held so the port reads 0 during reset and 1 right after
  assign cmd_ready = ready_r & ~reset;
  assign m_valid   = (fifo_cnt_r != {CntW{1'b0}});
  assign m_data    = fifo_data_r[rd_ptr_r];
  assign m_last    = m_valid & fifo_last_r[rd_ptr_r];
  assign pop_s     = m_valid & m_ready;
  assign push_s    = vld_pipe_r[RD_LAT-1];

  // Read issue and credit: outstanding counts the read on ce0, reads in the pipe and buffered words
  always_comb begin
    accept_s      = cmd_valid & cmd_ready;
    len_sat_s     = (cmd_len > MaxLen) ? MaxLen : cmd_len;
    first_issue_s = accept_s && (len_sat_s != {LenW{1'b0}});
    outstanding_s = SumW'(ce0) + SumW'(fifo_cnt_r);
    for (int i = 0; i < RD_LAT; i++) begin
      outstanding_s = outstanding_s + SumW'(vld_pipe_r[i]);
    end
    credit_ok_s = (outstanding_s - SumW'(pop_s)) < SumW'(FIFO_DEPTH);
    pending_s   = (state_r == ST_RUN) && (issued_r < len_r);
    issue_s     = pending_s && credit_ok_s;
    last_read_s = (issued_r == (len_r - LenW'(1)));
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (first_issue_s) begin
          state_nxt_s = (len_sat_s == LenW'(1)) ? ST_DRAIN : ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (issue_s && last_read_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (pop_s && m_last) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Control registers: state, status outputs and the memory read port
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      ready_r   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      ce0       <= 1'b0;
      ce_last_r <= 1'b0;
      address0  <= {AddressWidth{1'b0}};
      len_r     <= {LenW{1'b0}};
      issued_r  <= {LenW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == ST_IDLE);
      busy    <= (state_nxt_s != ST_IDLE);
      done    <= (accept_s && (len_sat_s == {LenW{1'b0}})) ||
                 ((state_r == ST_DRAIN) && pop_s && m_last);
      ce0     <= first_issue_s | issue_s;
      if (first_issue_s) begin
        address0  <= cmd_base;
        issued_r  <= LenW'(1);
        ce_last_r <= (len_sat_s == LenW'(1));
      end else if (issue_s) begin
        address0  <= addr_inc(address0);
        issued_r  <= issued_r + LenW'(1);
        ce_last_r <= last_read_s;
      end else begin
        ce_last_r <= 1'b0;
      end
      if (accept_s) begin
        len_r <= len_sat_s;
      end
    end
  end

  // Inflight tracking; clearing it on reset discards any q0 words still in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_r  <= {RD_LAT{1'b0}};
      last_pipe_r <= {RD_LAT{1'b0}};
    end else begin
      vld_pipe_r[0]  <= ce0;
      last_pipe_r[0] <= ce0 & ce_last_r;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_r[i]  <= vld_pipe_r[i-1];
        last_pipe_r[i] <= last_pipe_r[i-1];
      end
    end
  end

  // Skid FIFO pointers, occupancy and last flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= {PtrW{1'b0}};
      rd_ptr_r    <= {PtrW{1'b0}};
      fifo_cnt_r  <= {CntW{1'b0}};
      fifo_last_r <= {FIFO_DEPTH{1'b0}};
    end else begin
      if (push_s) begin
        fifo_last_r[wr_ptr_r] <= last_pipe_r[RD_LAT-1];
        wr_ptr_r              <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CntW'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CntW'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Skid FIFO data storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_data_r[wr_ptr_r] <= q0;
    end
  end

`ifdef KNN_RDR_PERF_EN
  // Saturating performance counters, restarted by every accepted command
  always_ff @(posedge clk) begin
    if (reset || accept_s) begin
      perf_stall_cycles  <= 32'd0;
      perf_credit_cycles <= 32'd0;
    end else begin
      if (m_valid && !m_ready && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (pending_s && !credit_ok_s && (perf_credit_cycles != 32'hFFFF_FFFF)) begin
        perf_credit_cycles <= perf_credit_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
